// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: default word width, count-width helper
// and the bit-count type for default-width instances.
package sipo_pkg;

    localparam int SIPO_WIDTH_DEF = 10;

    // Bits needed to hold the values 0..n-1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int SIPO_CNT_W_DEF = clog2(SIPO_WIDTH_DEF);

    typedef logic [SIPO_CNT_W_DEF-1:0] sipo_cnt_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter with enable and synchronous restart; restart with enable
// counts the current bit as the first bit of a new word.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF,
    parameter int CNT_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign last = (cnt_q == CNT_W'(WIDTH - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = en ? CNT_W'(1) : '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: MSB-first bits in, WIDTH-bit words out with valid/ready.
// Define SIPO_OVERRUN_FLAG_EN to add the sticky OVERRUN output.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             SI,
    input  logic             SI_VALID,
    input  logic             FRAME,
    output logic [WIDTH-1:0] PO,
    output logic             PO_VALID,
    input  logic             PO_READY
`ifdef SIPO_OVERRUN_FLAG_EN
    ,
    output logic             OVERRUN
`endif
);

    localparam int CNT_W = clog2(WIDTH);

    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             complete;
    logic [WIDTH-1:0] sh_next;

    // Only WIDTH-1 history bits are kept; the incoming bit completes the word.
    logic [WIDTH-2:0] sh_d;
    logic [WIDTH-2:0] sh_q;
    logic [WIDTH-1:0] po_d;
    logic [WIDTH-1:0] po_q;
    logic             po_valid_d;
    logic             po_valid_q;

    sipo_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (CLK),
        .rst     (ASYNCRESET),
        .en      (SI_VALID),
        .restart (FRAME),
        .cnt     (cnt),
        .last    (last)
    );

    always_comb begin
        sh_next    = {sh_q, SI};
        complete   = SI_VALID & last & ~FRAME;
        sh_d       = sh_q;
        po_d       = po_q;
        po_valid_d = po_valid_q;
        if (SI_VALID) begin
            sh_d = sh_next[WIDTH-2:0];
        end
        if (complete) begin
            po_d       = sh_next;
            po_valid_d = 1'b1;
        end else if (po_valid_q && PO_READY) begin
            po_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            sh_q       <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
        end
    end

    assign PO       = po_q;
    assign PO_VALID = po_valid_q;

`ifdef SIPO_OVERRUN_FLAG_EN
    logic overrun_d;
    logic overrun_q;

    // A completed word replacing one the consumer has not taken.
    always_comb begin
        overrun_d = overrun_q | (complete & po_valid_q & ~PO_READY);
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign OVERRUN = overrun_q;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: bit-queue reference model checked every cycle,
// plus hand-computed word expectations.
`timescale 1ns/1ps
module tb_sipo_deserializer;

    localparam int WIDTH = 10;

    logic             CLK = 1'b0;
    logic             ASYNCRESET = 1'b0;
    logic             SI = 1'b0;
    logic             SI_VALID = 1'b0;
    logic             FRAME = 1'b0;
    logic             PO_READY = 1'b0;
    logic [WIDTH-1:0] PO;
    logic             PO_VALID;
    logic             ovr;

    int checks = 0;
    int failures = 0;

    sipo_deserializer #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .SI         (SI),
        .SI_VALID   (SI_VALID),
        .FRAME      (FRAME),
        .PO         (PO),
        .PO_VALID   (PO_VALID),
        .PO_READY   (PO_READY)
`ifdef SIPO_OVERRUN_FLAG_EN
        ,
        .OVERRUN    (ovr)
`endif
    );

`ifndef SIPO_OVERRUN_FLAG_EN
    assign ovr = 1'b0;
`endif

    always #5 CLK = ~CLK;

    // Reference model: received bits since the last word boundary, and the output slot.
    bit               bits[$];
    logic [WIDTH-1:0] m_po = '0;
    logic             m_valid = 1'b0;
    logic             m_ovr = 1'b0;

    always @(posedge CLK or posedge ASYNCRESET) begin
        logic [WIDTH-1:0] w;
        logic             newword;
        if (ASYNCRESET) begin
            bits.delete();
            m_po    = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            newword = 1'b0;
            w       = '0;
            if (FRAME) bits.delete();
            if (SI_VALID) begin
                bits.push_back(SI);
                if (bits.size() == WIDTH) begin
                    foreach (bits[i]) w = {w[WIDTH-2:0], logic'(bits[i])};
                    bits.delete();
                    newword = 1'b1;
                end
            end
            if (newword) begin
`ifdef SIPO_OVERRUN_FLAG_EN
                if (m_valid && !PO_READY) m_ovr = 1'b1;
`endif
                m_po    = w;
                m_valid = 1'b1;
            end else if (m_valid && PO_READY) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("model_po_valid", 32'(PO_VALID), 32'(m_valid));
        chk("model_po", 32'(PO), 32'(m_po));
        chk("model_overrun", 32'(ovr), 32'(m_ovr));
    end

    task automatic cyc(input logic si, input logic v, input logic fr, input logic rdy);
        SI       = si;
        SI_VALID = v;
        FRAME    = fr;
        PO_READY = rdy;
        @(negedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy_last);
        for (int i = WIDTH - 1; i >= 0; i--) cyc(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : 1'b0);
    endtask

    task automatic do_reset();
        #2 ASYNCRESET = 1'b1;
        @(negedge CLK);
        #1 ASYNCRESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] pat;
        logic [WIDTH-1:0] piso;
        pat = 10'b1011001110;

        #1 ASYNCRESET = 1'b1;
        repeat (2) @(negedge CLK);
        #1 ASYNCRESET = 1'b0;
        chk("reset_po", 32'(PO), 32'h0);
        chk("reset_po_valid", 32'(PO_VALID), 32'h0);
        chk("reset_overrun", 32'(ovr), 32'h0);

        // 1: plain word, consumer stalled
        for (int i = WIDTH - 1; i >= 1; i--) cyc(pat[i], 1'b1, 1'b0, 1'b0);
        chk("t1_before_last", 32'(PO_VALID), 32'h0);
        cyc(pat[0], 1'b1, 1'b0, 1'b0);
        chk("t1_po", 32'(PO), 32'h2CE);
        chk("t1_po_valid", 32'(PO_VALID), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_po_hold", 32'(PO), 32'h2CE);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_consumed", 32'(PO_VALID), 32'h0);

        // 2: SI_VALID gaps
        for (int i = 0; i < 18; i++) cyc(pat[WIDTH-1-i/2], (i % 2) == 0, 1'b0, 1'b0);
        chk("t2_nine_bits", 32'(PO_VALID), 32'h0);
        cyc(pat[0], 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_po", 32'(PO), 32'h2CE);
        chk("t2_po_valid", 32'(PO_VALID), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 3: overrun
        send_word(10'h155, 1'b0);
        chk("t3_a", 32'(PO), 32'h155);
        send_word(10'h0AA, 1'b0);
        chk("t3_po", 32'(PO), 32'h0AA);
        chk("t3_po_valid", 32'(PO_VALID), 32'h1);
`ifdef SIPO_OVERRUN_FLAG_EN
        chk("t3_overrun", 32'(ovr), 32'h1);
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();

        // 4: consume on the completing edge
        send_word(10'h155, 1'b0);
        send_word(10'h0AA, 1'b1);
        chk("t4_po", 32'(PO), 32'h0AA);
        chk("t4_po_valid", 32'(PO_VALID), 32'h1);
        chk("t4_overrun", 32'(ovr), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 5a: FRAME alone clears a partial word
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        send_word(pat, 1'b0);
        chk("t5a_po", 32'(PO), 32'h2CE);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 5b: FRAME with a valid bit starts the new word
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5b_no_early", 32'(PO_VALID), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5b_po", 32'(PO), 32'h200);
        chk("t5b_po_valid", 32'(PO_VALID), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // 6: loopback from a PISO, load cycle then 10 shifts
        piso = 10'h155;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            cyc(piso[WIDTH-1], 1'b1, 1'b0, 1'b0);
            piso = piso << 1;
        end
        chk("t6_po", 32'(PO), 32'h155);
        chk("t6_po_valid", 32'(PO_VALID), 32'h1);

        // Reset mid-word with a word pending
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        #2 ASYNCRESET = 1'b1;
        #1;
        chk("rst_mid_po", 32'(PO), 32'h0);
        chk("rst_mid_po_valid", 32'(PO_VALID), 32'h0);
        @(negedge CLK);
        #1 ASYNCRESET = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_partial_gone", 32'(PO_VALID), 32'h0);
        chk("rst_po_zero", 32'(PO), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
